reg_decode_cut: RTL and testbench

//   Registered address-decode stage placed directly upstream of reg_demux.

---
 rtl/reg_decode_cut.sv | 176 +++++++++++++++++
 tb/tb_reg_decode_cut.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_decode_cut.sv
// Registered address-decode cut in front of a register-interface demux.
// Holds at most one transaction: decodes it, forwards hits to the demux,
// answers map misses and stalled slaves locally with an error response.

package reg_decode_cut_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } rsp_t;

  typedef struct packed {
    int unsigned          idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } rule_t;
endpackage

module reg_decode_cut #(
  parameter int unsigned NoPorts       = 0,
  parameter int unsigned NoRules       = 1,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 0,
  parameter type         req_t         = reg_decode_cut_pkg::req_t,
  parameter type         rsp_t         = reg_decode_cut_pkg::rsp_t,
  parameter type         rule_t        = reg_decode_cut_pkg::rule_t,
  localparam int unsigned SelectWidth  = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  req_t                   in_req_i,
  output rsp_t                   in_rsp_o,
  input  rule_t                  addr_map_i [NoRules],
  output logic [SelectWidth-1:0] out_select_o,
  output req_t                   out_req_o,
  input  rsp_t                   out_rsp_i
);

  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  req_t                   req_q, req_d;
  logic [SelectWidth-1:0] sel_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  req_t                   out_req_d;
  rsp_t                   in_rsp_d;

  logic [AddrWidth-1:0]   req_addr;
  logic                   dec_found;
  logic                   dec_hit;
  logic [SelectWidth-1:0] dec_sel;

  assign req_addr = in_req_i.addr;

  // Address decode: first (lowest-index) matching rule wins; out-of-range port is a miss.
  always_comb begin
    dec_found = 1'b0;
    dec_hit   = 1'b0;
    dec_sel   = '0;
    for (int unsigned r = 0; r < NoRules; r++) begin
      if (!dec_found && (req_addr >= addr_map_i[r].start_addr) &&
          (req_addr < addr_map_i[r].end_addr)) begin
        dec_found = 1'b1;
        if (addr_map_i[r].idx < NoPorts) begin
          dec_hit = 1'b1;
          dec_sel = SelectWidth'(addr_map_i[r].idx);
        end
      end
    end
  end

  // Next-state logic; outputs are derived from the next state so they register with it.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    sel_d     = out_select_o;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    out_req_d = '0;
    in_rsp_d  = '0;

    case (state_q)
      IDLE: begin
        if (in_req_i.valid) begin
          req_d   = in_req_i;
          cnt_d   = '0;
          rdata_d = '0;
          if (dec_hit) begin
            sel_d   = dec_sel;
            err_d   = 1'b0;
            state_d = BUSY;
          end else begin
            sel_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (out_rsp_i.ready) begin
          rdata_d = out_rsp_i.rdata;
          err_d   = out_rsp_i.error;
          state_d = RESP;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntWidth'(TimeoutCycles - 1))) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == BUSY) begin
      out_req_d       = req_d;
      out_req_d.valid = 1'b1;
    end
    if (state_d == RESP) begin
      in_rsp_d.rdata = rdata_d;
      in_rsp_d.error = err_d;
      in_rsp_d.ready = 1'b1;
    end
  end

  // State, stored transaction and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      out_select_o <= '0;
      out_req_o    <= '0;
      in_rsp_o     <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      out_select_o <= sel_d;
      out_req_o    <= out_req_d;
      in_rsp_o     <= in_rsp_d;
    end
  end

endmodule

// File: tb/tb_reg_decode_cut.sv
// Bench for reg_decode_cut: directed corner cases plus randomized transactions
// checked against a transaction-level model of decode, latency and timeout.

module tb_reg_decode_cut;
  import reg_decode_cut_pkg::*;

  localparam int unsigned NoPorts       = 4;
  localparam int unsigned NoRules       = 4;
  localparam int unsigned TimeoutCycles = 5;
  localparam int          Never         = 1000;

  logic       clk;
  logic       rst_n;
  req_t       in_req;
  rsp_t       in_rsp;
  rule_t      addr_map [NoRules];
  logic [1:0] out_sel;
  req_t       out_req;
  rsp_t       out_rsp;

  int  n_cmp = 0;
  int  n_err = 0;
  time last_ready_t = 0;

  reg_decode_cut #(
    .NoPorts      (NoPorts),
    .NoRules      (NoRules),
    .AddrWidth    (32),
    .DataWidth    (32),
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_req_i    (in_req),
    .in_rsp_o    (in_rsp),
    .addr_map_i  (addr_map),
    .out_select_o(out_sel),
    .out_req_o   (out_req),
    .out_rsp_i   (out_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode: the first rule whose range holds the address decides.
  function automatic void ref_decode(input logic [31:0] a, output bit hit, output int unsigned sel);
    hit = 1'b0;
    sel = 0;
    for (int i = 0; i < int'(NoRules); i++) begin
      if (a >= addr_map[i].start_addr && a < addr_map[i].end_addr) begin
        hit = (addr_map[i].idx < NoPorts);
        sel = hit ? addr_map[i].idx : 0;
        return;
      end
    end
  endfunction

  task automatic set_rule(input int i, input int unsigned idx, input logic [31:0] s, input logic [31:0] e);
    addr_map[i].idx        = idx;
    addr_map[i].start_addr = s;
    addr_map[i].end_addr   = e;
  endtask

  // One request from the master side; the slave answers in BUSY cycle delay+1.
  task automatic run_txn(input logic [31:0] a, input logic wr, input int delay,
                         input logic [31:0] sdata, input logic serr);
    bit          hit;
    bit          normal;
    bit          got;
    int unsigned sel;
    int          extra, exp_lat, exp_v, cyc, vcnt, bad_fld, bad_idle;
    logic [31:0] wd, exp_rd;
    logic [3:0]  ws;
    logic        exp_er;

    ref_decode(a, hit, sel);
    // A request raised in the response cycle is only picked up after one IDLE cycle.
    extra   = ($time == last_ready_t) ? 1 : 0;
    normal  = hit && (delay + 1 <= int'(TimeoutCycles));
    exp_lat = extra + (!hit ? 1 : (normal ? delay + 2 : int'(TimeoutCycles) + 1));
    exp_v   = !hit ? 0 : (normal ? delay + 1 : int'(TimeoutCycles));
    exp_rd  = normal ? sdata : 32'h0;
    exp_er  = normal ? serr : 1'b1;

    wd = $urandom;
    ws = 4'($urandom);
    in_req.addr  = a;
    in_req.write = wr;
    in_req.wdata = wd;
    in_req.wstrb = ws;
    in_req.valid = 1'b1;

    cyc = 0; vcnt = 0; bad_fld = 0; bad_idle = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      out_rsp = '0;
      if (out_req.valid) begin
        vcnt++;
        if (out_req.addr !== a || out_req.write !== wr || out_req.wdata !== wd ||
            out_req.wstrb !== ws || out_sel !== 2'(sel))
          bad_fld++;
        if (vcnt == delay + 1) begin
          out_rsp.rdata = sdata;
          out_rsp.error = serr;
          out_rsp.ready = 1'b1;
        end
      end
      if (in_rsp.ready) begin
        got = 1'b1;
      end else if (in_rsp.rdata !== 32'h0 || in_rsp.error !== 1'b0) begin
        bad_idle++;
      end
    end

    check("resp_seen", 64'(got), 64'(1));
    check("latency", 64'(cyc), 64'(exp_lat));
    check("out_valid_cycles", 64'(vcnt), 64'(exp_v));
    check("rdata", 64'(in_rsp.rdata), 64'(exp_rd));
    check("error", 64'(in_rsp.error), 64'(exp_er));
    check("busy_fields", 64'(bad_fld), 64'(0));
    check("idle_rsp_zero", 64'(bad_idle), 64'(0));

    in_req       = '0;
    last_ready_t = $time;
  endtask

  initial begin
    rst_n   = 1'b1;
    in_req  = '0;
    out_rsp = '0;
    for (int i = 0; i < int'(NoRules); i++) set_rule(i, 0, 32'h0, 32'h0);

    #2 rst_n = 1'b0;
    #1;
    check("rst_in_rsp", 64'(in_rsp), 64'(0));
    check("rst_out_req", 64'(out_req), 64'(0));
    check("rst_out_sel", 64'(out_sel), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Map A: disjoint ranges, one out-of-range port, one empty rule.
    set_rule(0, 0, 32'h000, 32'h100);
    set_rule(1, 2, 32'h100, 32'h200);
    set_rule(2, 7, 32'h400, 32'h500);
    set_rule(3, 1, 32'h600, 32'h600);
    run_txn(32'h104, 1'b0, 0, 32'hCAFE, 1'b0);
    @(negedge clk);
    run_txn(32'h300, 1'b1, 0, 32'h5555, 1'b0);
    @(negedge clk);
    run_txn(32'h0FF, 1'b0, 1, 32'h11, 1'b0);
    run_txn(32'h100, 1'b1, 2, 32'h22, 1'b0);
    run_txn(32'h1FF, 1'b0, 0, 32'h33, 1'b0);
    run_txn(32'h200, 1'b0, 0, 32'h44, 1'b0);
    run_txn(32'h450, 1'b0, 0, 32'h55, 1'b0);
    run_txn(32'h600, 1'b0, 0, 32'h66, 1'b0);

    // Map B: overlapping rules, lowest index wins.
    @(negedge clk);
    set_rule(0, 1, 32'h000, 32'h080);
    set_rule(1, 3, 32'h000, 32'h200);
    set_rule(2, 7, 32'h300, 32'h380);
    set_rule(3, 0, 32'h380, 32'h400);
    run_txn(32'h040, 1'b0, 0, 32'hA1, 1'b0);
    run_txn(32'h07F, 1'b0, 0, 32'hA2, 1'b0);
    run_txn(32'h080, 1'b0, 0, 32'hA3, 1'b0);
    run_txn(32'h310, 1'b0, 0, 32'hA4, 1'b0);

    // Timeout: silent slave, ready in the last allowed cycle, slave error.
    @(negedge clk);
    run_txn(32'h010, 1'b0, Never, 32'hBAD, 1'b0);
    @(negedge clk);
    run_txn(32'h010, 1'b0, 4, 32'h1234, 1'b0);
    @(negedge clk);
    run_txn(32'h390, 1'b1, 3, 32'h0, 1'b1);

    // Back-to-back requests with valid held through each response cycle.
    @(negedge clk);
    run_txn(32'h020, 1'b0, 0, 32'hB1, 1'b0);
    run_txn(32'h120, 1'b1, 1, 32'hB2, 1'b0);
    run_txn(32'h3A0, 1'b0, 0, 32'hB3, 1'b0);

    // Reset while BUSY aborts the transaction without a response.
    @(negedge clk);
    in_req.addr  = 32'h010;
    in_req.write = 1'b0;
    in_req.wdata = 32'h0;
    in_req.wstrb = 4'h0;
    in_req.valid = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", 64'(out_req.valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_req.valid), 64'(0));
    check("async_rst_rsp", 64'(in_rsp), 64'(0));
    in_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_rsp", 64'(in_rsp), 64'(0));
      check("post_rst_valid", 64'(out_req.valid), 64'(0));
    end
    run_txn(32'h090, 1'b1, 0, 32'hD00D, 1'b0);

    // Randomized traffic with periodically reshuffled maps.
    for (int n = 0; n < 160; n++) begin
      int          delay;
      int          gap;
      logic [31:0] s;
      if (n % 20 == 0) begin
        @(negedge clk);
        for (int i = 0; i < int'(NoRules); i++) begin
          s = 32'($urandom_range(0, 32'h400));
          set_rule(i, $urandom_range(0, 5), s, s + 32'($urandom_range(0, 32'h200)));
        end
      end
      delay = ($urandom_range(0, 7) == 0) ? Never : int'($urandom_range(0, 5));
      run_txn(32'($urandom_range(0, 32'h5FF)), 1'($urandom), delay, $urandom,
              ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
